// File: rtl/rot_seq_pkg.sv
// Shared types for the rotate sequencer.
// FSM state encoding and rotate direction constants.
package rot_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    RESP   = 2'd3
  } rot_state_e;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  // Single-bit rotate of a 32-bit-max vector, used to keep the
  // step logic in one place for any WIDTH up to 32.
  function automatic logic [31:0] rot1(
    input logic [31:0] v,
    input logic        dir,
    input int unsigned w
  );
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) begin
        if (dir == ROT_LEFT) begin
          r[i] = (i == 0) ? v[w-1] : v[i-1];
        end else begin
          r[i] = (i == w - 1) ? v[0] : v[i+1];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rot_sequencer_rotator.sv
// rotatorunit: loadable register that rotates one bit per enabled cycle.
// Load has priority over enable; both are driven only by the sequencer.
module rotatorunit
  import rot_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_rot;

  // One-position rotate of the held value in the requested direction.
  always_comb begin
    w_rot = r_q;
    if (dir == ROT_LEFT) begin
      w_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    end else begin
      w_rot = {r_q[0], r_q[WIDTH-1:1]};
    end
  end

  // Holding register: load a fresh operand or advance one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_in;
    end else if (en) begin
      r_q <= w_rot;
    end
  end

  assign data_out = r_q;

endmodule

// File: rtl/rot_sequencer.sv
// rot_sequencer: command/response wrapper sequencing a bit-serial rotator.
// Optional macro ROT_SEQ_SHORTEST_PATH_EN rotates the short way round.
module rot_sequencer
  import rot_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AMT_W-1:0] rsp_steps,
  output logic             busy
);

  rot_state_e r_state;
  rot_state_e w_next;

  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] r_steps;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;

  logic [AMT_W-1:0] w_steps;
  logic             w_dir;
  logic             w_accept;
  logic             w_load;
  logic             w_en;

`ifdef ROT_SEQ_SHORTEST_PATH_EN
  localparam logic [AMT_W-1:0] HALF = AMT_W'(WIDTH / 2);

  logic [AMT_W-1:0] w_neg_amt;

  // Past half a turn, go the other way: WIDTH-amt wraps to -amt.
  always_comb begin
    w_neg_amt = {AMT_W{1'b0}} - cmd_amt;
    w_steps   = cmd_amt;
    w_dir     = cmd_dir;
    if (cmd_amt > HALF) begin
      w_steps = w_neg_amt;
      w_dir   = ~cmd_dir;
    end
  end
`else
  // Rotate exactly as commanded.
  always_comb begin
    w_steps = cmd_amt;
    w_dir   = cmd_dir;
  end
`endif

  assign w_accept = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and rotator strobes.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_en      = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        if (cmd_abort) begin
          w_next = IDLE;
        end else begin
          w_load = 1'b1;
          w_next = (r_cnt != '0) ? ROTATE : RESP;
        end
      end
      ROTATE: begin
        if (cmd_abort) begin
          w_next = IDLE;
        end else begin
          w_en = 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            w_next = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Capture the command and count down the remaining steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_steps <= '0;
      r_dir   <= ROT_LEFT;
      r_data  <= '0;
    end else if (w_accept) begin
      r_cnt   <= w_steps;
      r_steps <= w_steps;
      r_dir   <= w_dir;
      r_data  <= cmd_data;
    end else if (w_en) begin
      r_cnt   <= r_cnt - AMT_W'(1);
    end
  end

  rotatorunit #(
    .WIDTH (WIDTH)
  ) u_rot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .en       (w_en),
    .dir      (r_dir),
    .data_in  (r_data),
    .data_out (rsp_data)
  );

  assign rsp_steps = r_steps;

endmodule

// File: tb/tb_rot_sequencer.sv
// Directed bench for rot_sequencer, WIDTH=8.
// Latency/steps expectations follow ROT_SEQ_SHORTEST_PATH_EN.
module tb_rot_sequencer;
  import rot_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [2:0] cmd_amt;
  logic       cmd_abort;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_steps;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rot_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_abort (cmd_abort),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_steps (rsp_steps),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command; return once it has been accepted (now in T+1).
  task automatic issue(
    input logic [7:0] d,
    input logic       dir,
    input logic [2:0] amt
  );
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_amt   = amt;
    chk("ready_at_issue", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_amt   = 3'd0;
  endtask

  // Wait for rsp_valid; lat counts cycles after the handshake cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_cmd(
    input string      tag,
    input logic [7:0] d,
    input logic       dir,
    input logic [2:0] amt,
    input logic [7:0] exp_d,
    input logic [2:0] exp_s,
    input int         exp_lat
  );
    int lat;
    issue(d, dir, amt);
    wait_rsp(lat);
    chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
    chk({tag, "_data"},  32'(rsp_data), 32'(exp_d));
    chk({tag, "_steps"}, 32'(rsp_steps), 32'(exp_s));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_vld_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_dir   = ROT_LEFT;
    cmd_amt   = 3'd0;
    cmd_abort = 1'b0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_steps", 32'(rsp_steps), 32'd0);
    rst_n = 1'b1;
    tick();

    run_cmd("c1", 8'hB4, ROT_LEFT, 3'd3, 8'hA5, 3'd3, 5);
    run_cmd("c2a", 8'h81, ROT_RIGHT, 3'd1, 8'hC0, 3'd1, 3);
    run_cmd("c2b", 8'h5A, ROT_LEFT, 3'd0, 8'h5A, 3'd0, 2);
`ifdef ROT_SEQ_SHORTEST_PATH_EN
    run_cmd("c3", 8'h01, ROT_LEFT, 3'd7, 8'h80, 3'd1, 3);
    run_cmd("c3b", 8'h96, ROT_LEFT, 3'd5, 8'hD2, 3'd3, 5);
`else
    run_cmd("c3", 8'h01, ROT_LEFT, 3'd7, 8'h80, 3'd7, 9);
    run_cmd("c3b", 8'h96, ROT_LEFT, 3'd5, 8'hD2, 3'd5, 7);
`endif

    // Case 4: stall the response, offer a competing command.
    issue(8'h3C, ROT_LEFT, 3'd2);
    wait_rsp(lat);
    chk("c4_lat", 32'(lat), 32'd4);
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    cmd_amt   = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk("c4_valid", 32'(rsp_valid), 32'd1);
      chk("c4_data",  32'(rsp_data),  32'hF0);
      chk("c4_steps", 32'(rsp_steps), 32'd2);
      chk("c4_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk("c4_idle_busy", 32'(busy), 32'd0);
    chk("c4_no_rsp",    32'(rsp_valid), 32'd0);

    // Case 5: abort in ROTATE.
    issue(8'hAA, ROT_LEFT, 3'd3);
    tick();
    chk("c5_busy", 32'(busy), 32'd1);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("c5_idle",  32'(cmd_ready), 32'd1);
    chk("c5_nbusy", 32'(busy),      32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("c5_norsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    run_cmd("c5n", 8'h0F, ROT_LEFT, 3'd4, 8'hF0, 3'd4, 6);

    // Case 6: reset mid-ROTATE.
    issue(8'h5A, ROT_RIGHT, 3'd3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("c6_ready", 32'(cmd_ready), 32'd1);
    chk("c6_busy",  32'(busy),      32'd0);
    chk("c6_valid", 32'(rsp_valid), 32'd0);
    chk("c6_data",  32'(rsp_data),  32'd0);
    chk("c6_steps", 32'(rsp_steps), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("c6_post_idle", 32'(cmd_ready), 32'd1);
    run_cmd("c6n", 8'h3C, ROT_RIGHT, 3'd2, 8'h0F, 3'd2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rot_sequencer.md
ROT_SEQUENCER -- requirements
Module: rot_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; power of two, >= 4.
REQ-002 SHALL have localparam AMT_W, value $clog2(WIDTH), rotate-amount width.
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_data  in  WIDTH  operand to rotate.
REQ-008 SHALL have port cmd_dir  in  1  0 = left, 1 = right.
REQ-009 SHALL have port cmd_amt  in  AMT_W  rotate distance in bit positions.
REQ-010 SHALL have port cmd_abort  in  1  cancel the in-flight command.
REQ-011 SHALL have port rsp_valid  out  1  result available.
REQ-012 SHALL have port rsp_ready  in  1  result consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_data  out  WIDTH  rotated result.
REQ-014 SHALL have port rsp_steps  out  AMT_W  single-bit rotate steps actually executed.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, ROTATE and RESP.
REQ-017 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, it SHALL capture dir, amt and data and go to LOAD.
REQ-018 In LOAD, it SHALL pulse the rotator load for exactly one cycle with the captured data, then go to ROTATE if the step count is > 0, else to RESP.
REQ-019 In ROTATE, it SHALL assert the rotator enable with the effective dir for exactly step-count consecutive cycles, decrementing a counter each cycle, then go to RESP.
REQ-020 Latency SHALL be: handshake at cycle T, rsp_valid first high at T+2+steps; amt=0 gives T+2.
REQ-021 In RESP, it SHALL hold rsp_valid=1 with rsp_data and rsp_steps stable until rsp_ready; on the handshake it SHALL return to IDLE, with cmd_ready high the next cycle (no same-cycle accept).
REQ-022 rsp_data SHALL equal cmd_data rotated by cmd_amt in cmd_dir, modulo WIDTH.
REQ-023 The rotator enable SHALL never be asserted outside ROTATE, and the rotator load never outside LOAD.
REQ-024 cmd_abort in LOAD or ROTATE SHALL force IDLE on the next edge with no response; in IDLE or RESP it SHALL be ignored.
REQ-025 cmd_valid while busy SHALL be ignored; the inputs need not be held.

Reset
REQ-026 On rst_n low, FSM=IDLE, counter=0, captured fields=0 and rotator state=0, asynchronously.
REQ-027 Reset values SHALL be cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_steps=0.
REQ-028 Reset asserted mid-operation SHALL discard the command silently; the first cycle after release SHALL be IDLE.

Configuration
REQ-029 Macro ROT_SEQ_SHORTEST_PATH_EN defined: if amt > WIDTH/2, effective dir SHALL be inverted and steps SHALL be WIDTH-amt; otherwise steps=amt, dir unchanged.
REQ-030 Macro undefined: steps SHALL always equal amt and dir SHALL be cmd_dir; rsp_data SHALL be identical in both builds, with only latency and rsp_steps differing.

Structure
REQ-031 Shared package rot_seq_pkg SHALL hold the FSM state enum typedef and the direction constants ROT_LEFT=0 and ROT_RIGHT=1.
REQ-032 There SHALL be one sub-module: the existing rotatorunit rotate register, instantiated with WIDTH, and driven only by this FSM; rsp_data SHALL come directly from its data_out.

Verification
REQ-033 Case 1: data=8'hB4, left, amt=3 -> rsp_data=8'hA5, rsp_steps=3, rsp_valid at T+5.
REQ-034 Case 2: data=8'h81, right, amt=1 -> rsp_data=8'hC0 at T+3; then amt=0 with data=8'h5A -> 8'h5A, rsp_steps=0, at T+2.
REQ-035 Case 3: data=8'h01, left, amt=7 -> 8'h80 in both builds. With the macro: rsp_steps=1, valid at T+3. Without it: rsp_steps=7, valid at T+9.
REQ-036 Case 4: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_steps stable, cmd_ready=0, and a new cmd_valid is ignored.
REQ-037 Case 5: cmd_abort during ROTATE -> IDLE next cycle, no rsp_valid. The next command 8'h0F, left, 4 -> 8'hF0.
REQ-038 Case 6: rst_n low mid-ROTATE -> all outputs at reset values immediately; after release, a fresh command completes correctly.
